// File: rtl/multicycle_state_regs.sv
// multicycle_state_regs: architectural and inter-cycle state for the multicycle RV32 core.
// Holds PC, OldPC, the instruction register, the 32x32 register file and the
// A/B/ALUOut/Data latches that carry values between controller states.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (forwards a same-edge register
// write into the A/B latches instead of the stale array entry).
module multicycle_state_regs #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCWrite,
    input  logic        IRWrite,
    input  logic        RegWrite,
    input  logic [31:0] Result,
    input  logic [31:0] ALUResult,
    input  logic [31:0] ReadData,
    output logic [31:0] PC,
    output logic [31:0] OldPC,
    output logic [31:0] Instr,
    output logic [6:0]  opcode,
    output logic [2:0]  func3,
    output logic [6:0]  func7,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [31:0] ALUOut,
    output logic [31:0] Data
);

    logic [31:0] regs [32];
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    // Register specifiers and decoded fields come straight from the held instruction.
    assign rs1    = Instr[19:15];
    assign rs2    = Instr[24:20];
    assign rd     = Instr[11:7];
    assign opcode = Instr[6:0];
    assign func3  = Instr[14:12];
    assign func7  = Instr[31:25];

    // Program counter: reloaded from the result mux only when the controller asks.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            PC <= RESET_PC;
        end else if (PCWrite) begin
            PC <= Result;
        end
    end

    // Instruction fetch capture: OldPC remembers the address the new instruction came from.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            Instr <= '0;
            OldPC <= '0;
        end else if (IRWrite) begin
            Instr <= ReadData;
            OldPC <= PC;
        end
    end

    // Register file write port; x0 is never written so it always reads back as zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite && (rd != 5'd0)) begin
            regs[rd] <= Result;
        end
    end

    // Read-port selection, optionally forwarding a write landing on the same edge.
    always_comb begin
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
`ifdef REGFILE_WRITE_BYPASS_EN
        if (RegWrite && (rd != 5'd0) && (rd == rs1)) begin
            rs1_data = Result;
        end
        if (RegWrite && (rd != 5'd0) && (rd == rs2)) begin
            rs2_data = Result;
        end
`else
        rs1_data = regs[rs1];
        rs2_data = regs[rs2];
`endif
    end

    // Inter-cycle latches load every cycle so each controller state sees last cycle's values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            A      <= '0;
            B      <= '0;
            ALUOut <= '0;
            Data   <= '0;
        end else begin
            A      <= rs1_data;
            B      <= rs2_data;
            ALUOut <= ALUResult;
            Data   <= ReadData;
        end
    end

endmodule
